// File: rtl/usb_data_buffer.sv
// ============================================================================
// usb_data_buffer: 64-byte first-word-fall-through FIFO shared by AHB and USB TX/RX.
// Rev 1.0
// ============================================================================
`default_nettype none

module usb_data_buffer #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       flush,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       store_rx_packet_data,
  input  logic [7:0] rx_packet_data,
  input  logic       get_tx_packet_data,
  input  logic       get_rx_data,
  output logic [7:0] tx_packet_data,
  output logic [7:0] rx_data,
  output logic [6:0] buffer_occupancy,
  output logic       buffer_error
);

  localparam int        AW     = 6;
  localparam logic [6:0] C_FULL = 7'(DEPTH);

  logic [7:0]    mem [0:DEPTH-1];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [6:0]    count_q, count_d;
  logic          err_q, err_d;

  logic       w_wr, w_rd, w_rd_ok, w_wr_ok, w_empty_req;
  logic [7:0] w_wdata;

  always_comb begin
    w_wr        = store_tx_data | store_rx_packet_data;
    w_rd        = get_tx_packet_data | get_rx_data;
    w_wdata     = store_tx_data ? tx_data : rx_packet_data;
    w_empty_req = clear | flush;
    w_rd_ok     = w_rd & (count_q != 7'd0);
    // A pop in the same edge frees a slot, so a write at full still lands.
    w_wr_ok     = w_wr & ((count_q != C_FULL) | w_rd_ok);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q
            | (store_tx_data & store_rx_packet_data)
            | (get_tx_packet_data & get_rx_data)
            | (w_rd & ~w_rd_ok)
            | (w_wr & ~w_wr_ok);

    if (w_empty_req) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (w_wr_ok) wptr_d = wptr_q + 1'b1;
      if (w_rd_ok) rptr_d = rptr_q + 1'b1;
      if (w_wr_ok & ~w_rd_ok)      count_d = count_q + 7'd1;
      else if (w_rd_ok & ~w_wr_ok) count_d = count_q - 7'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left unreset; count gates the head output instead.
  always_ff @(posedge clk) begin
    if (w_wr_ok & ~w_empty_req) mem[wptr_q] <= w_wdata;
  end

  always_comb begin
    tx_packet_data   = (count_q != 7'd0) ? mem[rptr_q] : 8'h00;
    rx_data          = tx_packet_data;
    buffer_occupancy = count_q;
    buffer_error     = err_q;
  end

endmodule

`default_nettype wire
